// File: rtl/fft_pkg.sv
// Shared constants and state type for the 64-point FFT
// address-generation unit.
package fft_pkg;

  localparam int N_LOG2    = 6;
  localparam int N_POINTS  = 64;
  localparam int ADDR_W    = 6;
  localparam int TW_ADDR_W = 5;
  localparam int N_BFLY    = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } agu_state_t;

endpackage

// File: rtl/fft_agu_if.sv
// Control/address bundle between fft_agu and the
// sample RAM / butterfly datapath.
interface fft_agu_if;
  import fft_pkg::*;

  logic                 start;
  logic [ADDR_W-1:0]    address_a;
  logic [ADDR_W-1:0]    address_b;
  logic [TW_ADDR_W-1:0] twiddle_addr;
  logic                 capture;
  logic                 write;
  logic                 busy;
  logic                 done;

  modport master (
    input  start,
    output address_a,
    output address_b,
    output twiddle_addr,
    output capture,
    output write,
    output busy,
    output done
  );

  modport slave (
    output start,
    input  address_a,
    input  address_b,
    input  twiddle_addr,
    input  capture,
    input  write,
    input  busy,
    input  done
  );

endinterface

// File: rtl/fft_addr_calc.sv
// Radix-2 butterfly address and twiddle index for a
// given (stage, butterfly index) pair. Combinational.
module fft_addr_calc
  import fft_pkg::*;
(
  input  logic [2:0]           stage,
  input  logic [4:0]           idx,
  output logic [ADDR_W-1:0]    address_a,
  output logic [ADDR_W-1:0]    address_b,
  output logic [TW_ADDR_W-1:0] twiddle_addr
);

  logic [ADDR_W-1:0]    sbit;
  logic [ADDR_W-1:0]    lo;
  logic [ADDR_W-1:0]    ext;
  logic [TW_ADDR_W-1:0] twm;

  // Insert a zero at bit `stage` by splitting
  // idx into low and high parts and shifting the high.
  always_comb begin
    sbit         = 6'd1 << stage;
    lo           = sbit - 6'd1;
    ext          = {1'b0, idx};
    address_a    = (ext & lo) | ((ext & ~lo) << 1);
    address_b    = address_a | sbit;
    twm          = idx & lo[TW_ADDR_W-1:0];
    twiddle_addr = twm << (3'd5 - stage);
  end

endmodule

// File: rtl/fft_agu.sv
// Sequencer for the in-place 64-point radix-2 FFT:
// 6 stages x 32 butterflies, each READ, WAIT*, WRITE.
module fft_agu
  import fft_pkg::*;
#(
  parameter int BFLY_LATENCY = 1
) (
  input  logic      clk,
  input  logic      reset_n,
  fft_agu_if.master bus
);

  localparam logic [2:0] WLAST =
    3'(BFLY_LATENCY > 1 ? BFLY_LATENCY - 2 : 0);

  agu_state_t state;
  logic [2:0] stage;
  logic [4:0] idx;
  logic [2:0] wcnt;

  logic [ADDR_W-1:0]    ca;
  logic [ADDR_W-1:0]    cb;
  logic [TW_ADDR_W-1:0] ctw;
  logic                 act;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      stage <= '0;
      idx   <= '0;
      wcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= READ;
            stage <= '0;
            idx   <= '0;
          end
        end
        READ: begin
          if (BFLY_LATENCY == 1) begin
            state <= WRITE;
          end else begin
            state <= WAIT;
            wcnt  <= '0;
          end
        end
        WAIT: begin
          wcnt <= wcnt + 3'd1;
          if (wcnt == WLAST) state <= WRITE;
        end
        WRITE: begin
          if (idx != 5'd31) begin
            idx   <= idx + 5'd1;
            state <= READ;
          end else if (stage != 3'd5) begin
            stage <= stage + 3'd1;
            idx   <= '0;
            state <= READ;
          end else begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fft_addr_calc u_calc (
    .stage        (stage),
    .idx          (idx),
    .address_a    (ca),
    .address_b    (cb),
    .twiddle_addr (ctw)
  );

  // Decoded from registered state only, so an async
  // reset clears every output immediately.
  assign act = (state == READ) ||
               (state == WAIT) ||
               (state == WRITE);

  assign bus.busy         = act;
  assign bus.capture      = (state == READ);
  assign bus.write        = (state == WRITE);
  assign bus.done         = (state == DONE);
  assign bus.address_a    = act ? ca  : '0;
  assign bus.address_b    = act ? cb  : '0;
  assign bus.twiddle_addr = act ? ctw : '0;

endmodule
